// File: rtl/ice40_himax_pkg.sv
// Shared definitions for the HM01B0 capture path: FSM encoding, datapath widths
// and the crop/subsample window test.
package ice40_himax_pkg;

  localparam int CAM_CNT_W = 10;
  localparam int PIX_W     = 8;
  localparam int WORD_W    = 32;

  typedef logic [1:0] cap_state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // True when a line/pixel position falls on a kept sample of the window.
  function automatic logic in_window(input logic [CAM_CNT_W-1:0] cnt, input int off,
                                     input int len, input int sub);
    int d;
    d = int'(cnt) - off;
    in_window = (d >= 0) && (d < len * sub) && ((d % sub) == 0);
  endfunction

endpackage

// File: rtl/ice40_himax_pix_packer.sv
// Packs kept 8-bit pixels into 32-bit words, first pixel in the low byte.
// The lane index restarts on every line so a trailing partial word is dropped.
module ice40_himax_pix_packer
  import ice40_himax_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic              pix_vld,
  input  logic [PIX_W-1:0]  pix,
  output logic              word_vld,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        lane_q, lane_d, lane_cur_s;
  logic [WORD_W-1:0] word_q, word_d;
  logic              vld_q, vld_d;

  // Lane select, byte shift-in and word-complete strobe.
  always_comb begin
    lane_cur_s = line_start ? 2'd0 : lane_q;
    lane_d     = lane_cur_s;
    word_d     = word_q;
    vld_d      = 1'b0;
    if (pix_vld) begin
      word_d = {pix, word_q[WORD_W-1:PIX_W]};
      lane_d = lane_cur_s + 2'd1;
      vld_d  = (lane_cur_s == 2'd3);
    end else begin
      vld_d  = 1'b0;
    end
  end

  // Packer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= 2'd0;
      word_q <= {WORD_W{1'b0}};
      vld_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_vld = vld_q;
  assign word     = word_q;

endmodule

// File: rtl/ice40_himax_video_capture.sv
// HM01B0 capture stage: waits for a frame start on request, crops/subsamples a
// window, writes packed words to the frame buffer and raises o_vid_rdy.
module ice40_himax_video_capture
  import ice40_himax_pkg::*;
#(
  parameter int X_OFF  = 2,
  parameter int Y_OFF  = 2,
  parameter int WIN_W  = 160,
  parameter int WIN_H  = 160,
  parameter int SUB    = 2,
  parameter int ADDR_W = 13
) (
  input  logic              i_pclk_in,
  input  logic              resetn,
  input  logic              i_cam_vsync,
  input  logic              i_cam_hsync,
  input  logic [PIX_W-1:0]  i_cam_data,
  input  logic              i_cap_req,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [WORD_W-1:0] o_wdata,
  output logic              o_vid_rdy,
  output logic              o_frame_err
);

  localparam int                N_WORDS   = WIN_W * WIN_H / 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  logic                 vs1_q, vs1_d, vs2_q, vs2_d;
  logic                 hs1_q, hs1_d, hs2_q, hs2_d;
  logic                 req1_q, req1_d;
  logic [PIX_W-1:0]     dat1_q, dat1_d;
  logic [CAM_CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d, x_cur_s;
  cap_state_t           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d, waddr_q, waddr_d;
  logic [WORD_W-1:0]    wdata_q, wdata_d;
  logic                 we_q, we_d, rdy_q, rdy_d, err_q, err_d;
  logic                 vs_rise_s, hs_rise_s, hs_fall_s, keep_s;
  logic                 wr_ok_s, final_wr_s, word_vld_s;
  logic [WORD_W-1:0]    word_s;

  // Input stage, edge detection, line/pixel counters and window test.
  always_comb begin
    vs1_d  = i_cam_vsync;
    hs1_d  = i_cam_hsync;
    dat1_d = i_cam_data;
    req1_d = i_cap_req;
    vs2_d  = vs1_q;
    hs2_d  = hs1_q;

    vs_rise_s = vs1_q & ~vs2_q;
    hs_rise_s = hs1_q & ~hs2_q;
    hs_fall_s = ~hs1_q & hs2_q;

    // The first pixel of a line arrives together with the hsync rise.
    x_cur_s = hs_rise_s ? {CAM_CNT_W{1'b0}} : x_cnt_q;
    if (hs1_q) begin
      x_cnt_d = x_cur_s + CAM_CNT_W'(1);
    end else begin
      x_cnt_d = x_cnt_q;
    end

    if (vs_rise_s) begin
      y_cnt_d = {CAM_CNT_W{1'b0}};
    end else if (hs_fall_s) begin
      y_cnt_d = y_cnt_q + CAM_CNT_W'(1);
    end else begin
      y_cnt_d = y_cnt_q;
    end

    keep_s = (state_q == ST_CAPTURE) && req1_q && hs1_q &&
             in_window(x_cur_s, X_OFF, WIN_W, SUB) &&
             in_window(y_cnt_q, Y_OFF, WIN_H, SUB);
  end

  ice40_himax_pix_packer u_packer (
    .clk        (i_pclk_in),
    .rst_n      (resetn),
    .line_start (hs_rise_s),
    .pix_vld    (keep_s),
    .pix        (dat1_q),
    .word_vld   (word_vld_s),
    .word       (word_s)
  );

  // Capture FSM, write port and saturating word address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    // A word still in flight when a new frame starts belongs to the old frame.
    wr_ok_s    = word_vld_s && (state_q == ST_CAPTURE) && req1_q && !vs_rise_s;
    final_wr_s = we_q && (waddr_q == LAST_ADDR);
    we_d       = wr_ok_s;

    if (wr_ok_s) begin
      waddr_d = addr_q;
      wdata_d = word_s;
      if (addr_q != LAST_ADDR) begin
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        addr_d = addr_q;
      end
    end else begin
      waddr_d = waddr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (req1_q) begin
          state_d = ST_ARMED;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!req1_q) begin
          state_d = ST_IDLE;
        end else if (vs_rise_s) begin
          state_d = ST_CAPTURE;
          addr_d  = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_CAPTURE: begin
        if (!req1_q) begin
          state_d = ST_IDLE;
        end else if (final_wr_s) begin
          state_d = ST_DONE;
        end else if (vs_rise_s) begin
          err_d  = 1'b1;
          addr_d = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        if (!req1_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rdy_d = (state_d == ST_DONE);
  end

  // All top-level state.
  always_ff @(posedge i_pclk_in or negedge resetn) begin
    if (!resetn) begin
      vs1_q   <= 1'b0;
      vs2_q   <= 1'b0;
      hs1_q   <= 1'b0;
      hs2_q   <= 1'b0;
      req1_q  <= 1'b0;
      dat1_q  <= {PIX_W{1'b0}};
      x_cnt_q <= {CAM_CNT_W{1'b0}};
      y_cnt_q <= {CAM_CNT_W{1'b0}};
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      waddr_q <= {ADDR_W{1'b0}};
      wdata_q <= {WORD_W{1'b0}};
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      hs1_q   <= hs1_d;
      hs2_q   <= hs2_d;
      req1_q  <= req1_d;
      dat1_q  <= dat1_d;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign o_we        = we_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_vid_rdy   = rdy_q;
  assign o_frame_err = err_q;

endmodule
